if_fetch_unit: RTL and testbench

Instruction fetch unit of the ARM pipeline, sitting directly upstream of the IF/ID stage register. Owns the fetch program counter, issues word requests to a variable-latency instruction memory over a req/ready handshake, buffers returned words in a small prefetch FIFO, and presents one {PC+4, instruction} pair per cycle to the IF/ID register. Handles branch redirects, including squashing a request still in flight, and back-pressure from the pipeline freeze signal.

---
 rtl/if_fetch_unit.sv | 125 ++++++++++++
 tb/tb_if_fetch_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, runs one outstanding request at a time
// against a variable-latency instruction memory and buffers words in a prefetch FIFO.
//
// state   | meaning
// IDLE    | no request outstanding; waits for FIFO space or absorbs a redirect
// REQ     | request to fetch_pc outstanding; pushes {fetch_pc+4, word} on handshake
// DISCARD | request outstanding but squashed; word dropped, then jump to redirect_pc
module if_fetch_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branchTaken,
  input  logic [31:0] branchAddr,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memReady,
  input  logic [31:0] memData,
  output logic [31:0] PC,
  output logic [31:0] instruction,
  output logic        valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [31:0]   redirect_pc, redirect_pc_nxt;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [63:0]   fifo_q [DEPTH];
  logic          push, pop;
  logic [31:0]   target;
  logic          unused_addr_bits;

  assign target           = {branchAddr[31:2], 2'b00};
  assign unused_addr_bits = ^branchAddr[1:0];

  assign valid       = (count != '0);
  assign PC          = valid ? fifo_q[rd_ptr][63:32] : 32'h0;
  assign instruction = valid ? fifo_q[rd_ptr][31:0]  : 32'h0;
  assign memReq      = (state != IDLE);
  assign memAddr     = fetch_pc;
  assign pop         = valid && !freeze && !branchTaken;

  always_comb begin
    state_nxt       = state;
    fetch_pc_nxt    = fetch_pc;
    redirect_pc_nxt = redirect_pc;
    push            = 1'b0;
    case (state)
      IDLE: begin
        if (branchTaken)
          fetch_pc_nxt = target;
        else if (count < CW'(DEPTH))
          state_nxt = REQ;
      end
      REQ: begin
        if (branchTaken && !memReady) begin
          redirect_pc_nxt = target;
          state_nxt       = DISCARD;
        end else if (branchTaken) begin
          fetch_pc_nxt = target;
          state_nxt    = IDLE;
        end else if (memReady) begin
          push         = 1'b1;
          fetch_pc_nxt = fetch_pc + 32'd4;
          // Stop once this push (net of a same-edge pop) fills the FIFO.
          if ((count + CW'(1) - CW'(pop)) >= CW'(DEPTH))
            state_nxt = IDLE;
        end
      end
      DISCARD: begin
        if (branchTaken)
          redirect_pc_nxt = target;
        if (memReady) begin
          fetch_pc_nxt = branchTaken ? target : redirect_pc;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fetch_pc    <= 32'h0;
      redirect_pc <= 32'h0;
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      redirect_pc <= redirect_pc_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (branchTaken) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: the head is masked by valid.
  always_ff @(posedge clk) begin
    if (push)
      fifo_q[wr_ptr] <= {fetch_pc + 32'd4, memData};
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit with a combinational memory model
// whose word at address a is a ^ 32'hC0DE0000.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branchTaken = 1'b0;
  logic [31:0] branchAddr = 32'h0;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memReady = 1'b0;
  logic [31:0] memData;
  logic [31:0] PC;
  logic [31:0] instruction;
  logic        valid;

  int vectors = 0;
  int errors  = 0;

  if_fetch_unit #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branchTaken(branchTaken),
    .branchAddr(branchAddr), .memReq(memReq), .memAddr(memAddr),
    .memReady(memReady), .memData(memData), .PC(PC),
    .instruction(instruction), .valid(valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE0000;
  endfunction

  assign memData = mem_word(memAddr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; branchTaken = 1'b0; freeze = 1'b0; memReady = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    vectors++; if (memReq !== 1'b0) begin errors++; $display("FAIL reset_memReq got %0b exp 0", memReq); end
    vectors++; if (memAddr !== 32'h0) begin errors++; $display("FAIL reset_memAddr got %h exp 0", memAddr); end
    vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", valid); end
    vectors++; if (PC !== 32'h0) begin errors++; $display("FAIL reset_PC got %h exp 0", PC); end
    vectors++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", instruction); end
  endtask

  task automatic test_stream();
    do_reset();
    memReady = 1'b1;
    tick();
    vectors++; if (memReq !== 1'b1 || memAddr !== 32'h0 || valid !== 1'b0) begin
      errors++; $display("FAIL stream_first_req got req=%0b addr=%h valid=%0b exp 1/0/0", memReq, memAddr, valid);
    end
    for (int k = 2; k <= 7; k++) begin
      tick();
      vectors++;
      if (valid !== 1'b1 || PC !== 32'(4*(k-1)) || instruction !== mem_word(32'(4*(k-2))) || memAddr !== 32'(4*(k-1))) begin
        errors++;
        $display("FAIL stream_k%0d got valid=%0b PC=%h ins=%h addr=%h exp 1/%h/%h/%h", k, valid, PC, instruction,
                 memAddr, 32'(4*(k-1)), mem_word(32'(4*(k-2))), 32'(4*(k-1)));
      end
    end
  endtask

  task automatic fill_frozen();
    do_reset();
    freeze = 1'b1; memReady = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_freeze();
    logic [31:0] exp_pc [3];
    int idx;
    exp_pc[0] = 32'h8; exp_pc[1] = 32'hC; exp_pc[2] = 32'h10;
    fill_frozen();
    vectors++; if (memReq !== 1'b0 || memAddr !== 32'h8 || PC !== 32'h4 || valid !== 1'b1) begin
      errors++; $display("FAIL freeze_full got req=%0b addr=%h PC=%h valid=%0b exp 0/8/4/1", memReq, memAddr, PC, valid);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++; if (memReq !== 1'b0 || PC !== 32'h4) begin
        errors++; $display("FAIL freeze_hold%0d got req=%0b PC=%h exp 0/4", i, memReq, PC);
      end
    end
    freeze = 1'b0;
    #1;
    vectors++; if (PC !== 32'h4 || instruction !== mem_word(32'h0)) begin
      errors++; $display("FAIL freeze_release_head got PC=%h ins=%h exp 4/%h", PC, instruction, mem_word(32'h0));
    end
    idx = 0;
    for (int c = 0; c < 8 && idx < 3; c++) begin
      tick();
      if (valid) begin
        vectors++; if (PC !== exp_pc[idx] || instruction !== mem_word(exp_pc[idx] - 32'd4)) begin
          errors++; $display("FAIL freeze_drain%0d got PC=%h ins=%h exp %h/%h", idx, PC, instruction,
                             exp_pc[idx], mem_word(exp_pc[idx] - 32'd4));
        end
        idx++;
      end
    end
    vectors++; if (idx != 3) begin errors++; $display("FAIL freeze_drain_timeout got %0d entries exp 3", idx); end
  endtask

  task automatic test_flush_full();
    fill_frozen();
    branchTaken = 1'b1; branchAddr = 32'h100;
    tick();
    branchTaken = 1'b0;
    vectors++; if (valid !== 1'b0 || memAddr !== 32'h100 || memReq !== 1'b0) begin
      errors++; $display("FAIL flush_next got valid=%0b addr=%h req=%0b exp 0/100/0", valid, memAddr, memReq);
    end
    tick();
    vectors++; if (memReq !== 1'b1 || valid !== 1'b0) begin
      errors++; $display("FAIL flush_req got req=%0b valid=%0b exp 1/0", memReq, valid);
    end
    tick();
    vectors++; if (valid !== 1'b1 || PC !== 32'h104 || instruction !== mem_word(32'h100)) begin
      errors++; $display("FAIL flush_first got valid=%0b PC=%h ins=%h exp 1/104/%h", valid, PC, instruction, mem_word(32'h100));
    end
  endtask

  task automatic test_discard();
    do_reset();
    memReady = 1'b1;
    tick(); tick(); tick();
    memReady = 1'b0; branchTaken = 1'b1; branchAddr = 32'h40;
    for (int i = 0; i < 3; i++) begin
      tick();
      branchTaken = 1'b0;
      vectors++; if (memReq !== 1'b1 || memAddr !== 32'h8 || valid !== 1'b0) begin
        errors++; $display("FAIL discard_wait%0d got req=%0b addr=%h valid=%0b exp 1/8/0", i, memReq, memAddr, valid);
      end
    end
    memReady = 1'b1;
    tick();
    vectors++; if (memReq !== 1'b0 || memAddr !== 32'h40 || valid !== 1'b0) begin
      errors++; $display("FAIL discard_drop got req=%0b addr=%h valid=%0b exp 0/40/0", memReq, memAddr, valid);
    end
    tick();
    vectors++; if (memReq !== 1'b1 || memAddr !== 32'h40 || valid !== 1'b0) begin
      errors++; $display("FAIL discard_newreq got req=%0b addr=%h valid=%0b exp 1/40/0", memReq, memAddr, valid);
    end
    tick();
    vectors++; if (valid !== 1'b1 || PC !== 32'h44 || instruction !== mem_word(32'h40)) begin
      errors++; $display("FAIL discard_first got valid=%0b PC=%h ins=%h exp 1/44/%h", valid, PC, instruction, mem_word(32'h40));
    end
  endtask

  task automatic test_branch_ready();
    do_reset();
    memReady = 1'b1;
    tick(); tick(); tick();
    branchTaken = 1'b1; branchAddr = 32'h103;
    tick();
    branchTaken = 1'b0;
    vectors++; if (valid !== 1'b0 || memAddr !== 32'h100 || memReq !== 1'b0) begin
      errors++; $display("FAIL brready_next got valid=%0b addr=%h req=%0b exp 0/100/0", valid, memAddr, memReq);
    end
    tick();
    vectors++; if (valid !== 1'b0 || memAddr !== 32'h100) begin
      errors++; $display("FAIL brready_req got valid=%0b addr=%h exp 0/100", valid, memAddr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (valid !== 1'b1 || PC !== 32'(32'h104 + 4*i) || instruction !== mem_word(32'(32'h100 + 4*i))) begin
        errors++; $display("FAIL brready_stream%0d got valid=%0b PC=%h ins=%h exp 1/%h/%h", i, valid, PC, instruction,
                           32'(32'h104 + 4*i), mem_word(32'(32'h100 + 4*i)));
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    memReady = 1'b1;
    tick(); tick();
    branchTaken = 1'b1; branchAddr = 32'hFFFFFFFE;
    tick();
    branchTaken = 1'b0;
    tick(); tick();
    vectors++; if (valid !== 1'b1 || PC !== 32'h0 || instruction !== mem_word(32'hFFFFFFFC) || memAddr !== 32'h0) begin
      errors++; $display("FAIL wrap got valid=%0b PC=%h ins=%h addr=%h exp 1/0/%h/0", valid, PC, instruction, memAddr,
                         mem_word(32'hFFFFFFFC));
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    memReady = 1'b0;
    tick(); tick(); tick();
    memReady = 1'b1;
    tick(); tick();
    #1;
    rst = 1'b1;
    #1;
    vectors++; if (memReq !== 1'b0 || valid !== 1'b0 || PC !== 32'h0 || instruction !== 32'h0 || memAddr !== 32'h0) begin
      errors++; $display("FAIL async_rst got req=%0b valid=%0b PC=%h ins=%h addr=%h exp all 0", memReq, valid, PC,
                         instruction, memAddr);
    end
    tick();
    rst = 1'b0;
    tick();
    vectors++; if (memReq !== 1'b1 || memAddr !== 32'h0) begin
      errors++; $display("FAIL async_restart got req=%0b addr=%h exp 1/0", memReq, memAddr);
    end
    tick();
    vectors++; if (valid !== 1'b1 || PC !== 32'h4 || instruction !== mem_word(32'h0)) begin
      errors++; $display("FAIL async_first got valid=%0b PC=%h ins=%h exp 1/4/%h", valid, PC, instruction, mem_word(32'h0));
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_freeze();
    test_flush_full();
    test_discard();
    test_branch_ready();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
